// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 device-to-host frame receiver.
// Optional parity checking is selected with the PS2_PARITY_CHECK_EN macro in the top level.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int   PS2_DATA_BITS = 8;
  localparam int   PS2_CNT_W     = $clog2(PS2_DATA_BITS);
  localparam logic PS2_START_LVL = 1'b0;
  localparam logic PS2_STOP_LVL  = 1'b1;

  // Odd parity over the data byte and the received parity bit.
  function automatic logic ps2_odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                             input logic par_bit);
    return (^data) ^ par_bit;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises both PS/2 lines and glitch-filters the clock line, producing a
// one-cycle strobe on each falling edge of the filtered clock.
module ps2_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic iClk,
  input  logic iReset_n,
  input  logic iPs2Clk,
  input  logic iPs2Data,
  output logic oSyncData,
  output logic oFallStrobe
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_filt;
  logic                   r_fall;
  logic                   w_clk_s;
  logic                   w_differs;
  logic                   w_settled;

  // Lines idle high, so the chains reset to 1 to avoid a false edge on release.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], iPs2Clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], iPs2Data};
    end
  end

  assign w_clk_s   = r_clk_sync[SYNC_STAGES-1];
  assign w_differs = (w_clk_s != r_filt);
  assign w_settled = w_differs && (r_cnt == CNT_W'(FILTER_LEN - 1));

  // r_cnt counts consecutive samples disagreeing with the filtered level.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_cnt  <= '0;
      r_filt <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_fall <= w_settled && !w_clk_s;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_settled) begin
        r_filt <= w_clk_s;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign oSyncData   = r_data_sync[SYNC_STAGES-1];
  assign oFallStrobe = r_fall;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 keyboard frame receiver: deserialises 11-bit frames into bytes with a one-cycle oFlag.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity does not hold.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iPs2Clk,
  input  logic       iPs2Data,
  output logic       oFlag,
  output logic [7:0] oData,
  output logic       oErr
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  ps2_state_e               r_state;
  ps2_state_e               w_state_nxt;
  logic [PS2_CNT_W-1:0]     r_bitcnt;
  logic [PS2_CNT_W-1:0]     w_bitcnt_nxt;
  logic [PS2_DATA_BITS-1:0] r_shift;
  logic [PS2_DATA_BITS-1:0] w_shift_nxt;
  logic [TO_W-1:0]          r_tcnt;
  logic [7:0]               r_data;
  logic                     r_flag;
  logic                     r_err;
  logic                     w_flag_nxt;
  logic                     w_err_nxt;
  logic                     w_load;
  logic                     w_par_ok;
  logic                     w_timeout;
  logic                     w_sync_data;
  logic                     w_strobe;

  ps2_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filter (
    .iClk        (iClk),
    .iReset_n    (iReset_n),
    .iPs2Clk     (iPs2Clk),
    .iPs2Data    (iPs2Data),
    .oSyncData   (w_sync_data),
    .oFallStrobe (w_strobe)
  );

`ifdef PS2_PARITY_CHECK_EN
  logic r_parity;
  logic w_parity_nxt;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) r_parity <= 1'b0;
    else           r_parity <= w_parity_nxt;
  end

  always_comb begin
    w_parity_nxt = r_parity;
    if (w_strobe && r_state == PARITY) w_parity_nxt = w_sync_data;
  end

  assign w_par_ok = ps2_odd_parity_ok(r_shift, r_parity);
`else
  // Parity bit is clocked through the PARITY state but not retained.
  assign w_par_ok = 1'b1;
`endif

  // A strobe in the same cycle as expiry keeps the frame alive.
  assign w_timeout = (r_state != IDLE) && (r_tcnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_tcnt   <= '0;
      r_data   <= 8'h00;
      r_flag   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_flag   <= w_flag_nxt;
      r_err    <= w_err_nxt;
      if (w_load) r_data <= r_shift;
      if (w_strobe || r_state == IDLE) r_tcnt <= '0;
      else                             r_tcnt <= r_tcnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_flag_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_load       = 1'b0;
    if (w_strobe) begin
      unique case (r_state)
        IDLE: begin
          if (w_sync_data == PS2_START_LVL) begin
            w_state_nxt  = DATA;
            w_bitcnt_nxt = '0;
          end
        end
        DATA: begin
          w_shift_nxt = {w_sync_data, r_shift[PS2_DATA_BITS-1:1]};
          if (r_bitcnt == PS2_CNT_W'(PS2_DATA_BITS - 1)) begin
            w_state_nxt  = PARITY;
            w_bitcnt_nxt = '0;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 1'b1;
          end
        end
        PARITY: begin
          w_state_nxt = STOP;
        end
        STOP: begin
          w_state_nxt = IDLE;
          if (w_sync_data == PS2_STOP_LVL && w_par_ok) begin
            w_load     = 1'b1;
            w_flag_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt  = IDLE;
      w_bitcnt_nxt = '0;
      w_err_nxt    = 1'b1;
    end
  end

  assign oFlag = r_flag;
  assign oData = r_data;
  assign oErr  = r_err;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed plus randomized bench for ps2_frame_receiver; honours PS2_PARITY_CHECK_EN.
module tb_ps2_frame_receiver;

  localparam int HP      = 400;
  localparam int HP_FAST = 50;
  localparam int TO      = 2000;

  logic       iClk = 1'b0;
  logic       iReset_n = 1'b0;
  logic       iPs2Clk = 1'b1;
  logic       iPs2Data = 1'b1;
  logic       oFlag;
  logic [7:0] oData;
  logic       oErr;

  int n_assert = 0;
  int n_fail   = 0;
  int flag_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int f0, e0;
  logic [7:0] exp_data;

  ps2_frame_receiver #(
    .SYNC_STAGES    (2),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .iPs2Clk  (iPs2Clk),
    .iPs2Data (iPs2Data),
    .oFlag    (oFlag),
    .oData    (oData),
    .oErr     (oErr)
  );

  always #5 iClk = ~iClk;

  always @(negedge iClk) begin
    if (oFlag === 1'b1) flag_cnt <= flag_cnt + 1;
    if (oErr === 1'b1)  err_cnt  <= err_cnt + 1;
    if (oFlag === 1'b1 && oErr === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // Reference rule: frame good iff stop high and (parity disabled or data+parity has odd ones).
  function automatic logic frame_good(input logic [7:0] d, input logic p, input logic s);
    int ones = int'(p);
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
`ifdef PS2_PARITY_CHECK_EN
    return s && (ones % 2 == 1);
`else
    return s;
`endif
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge iClk);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits, input int hp);
    for (int i = 0; i < nbits; i++) begin
      iPs2Data = bits[i];
      cycles(hp);
      iPs2Clk = 1'b0;
      cycles(hp);
      iPs2Clk = 1'b1;
    end
    cycles(hp);
    @(negedge iClk);
  endtask

  task automatic frame_check(input string tag, input logic [7:0] d, input logic p,
                             input logic s, input int hp);
    logic good;
    good = frame_good(d, p, s);
    f0 = flag_cnt;
    e0 = err_cnt;
    send_bits({s, p, d, 1'b0}, 11, hp);
    if (good) exp_data = d;
    chk({tag, " flag"}, flag_cnt - f0, good ? 1 : 0);
    chk({tag, " err"},  err_cnt - e0,  good ? 0 : 1);
    chk({tag, " data"}, oData, exp_data);
  endtask

  initial begin
    exp_data = 8'h00;
    cycles(5);
    @(negedge iClk);
    chk("reset flag", oFlag, 0);
    chk("reset err",  oErr, 0);
    chk("reset data", oData, 8'h00);
    iReset_n = 1'b1;
    cycles(20);

    // T1
    frame_check("T1 1C", 8'h1C, odd_par(8'h1C), 1'b1, HP);
    // T2 back-to-back
    frame_check("T2 F0", 8'hF0, odd_par(8'hF0), 1'b1, HP);
    frame_check("T2 1C", 8'h1C, odd_par(8'h1C), 1'b1, HP);
    // T3 bad stop bit
    frame_check("T3 16 stop0", 8'h16, odd_par(8'h16), 1'b0, HP);
    // T4 wrong parity
    frame_check("T4 1C par1", 8'h1C, 1'b1, 1'b1, HP);

    // T5 timeout after start + 4 data bits
    f0 = flag_cnt;
    e0 = err_cnt;
    send_bits({1'b1, 1'b0, 8'h0B, 1'b0}, 5, HP);
    iPs2Data = 1'b1;
    cycles(1000);
    @(negedge iClk);
    chk("T5 no early err", err_cnt - e0, 0);
    cycles(400);
    @(negedge iClk);
    chk("T5 timeout err", err_cnt - e0, 1);
    chk("T5 timeout flag", flag_cnt - f0, 0);
    frame_check("T5 1B", 8'h1B, odd_par(8'h1B), 1'b1, HP);

    // Randomized frames at a faster PS/2 clock
    for (int k = 0; k < 8; k++) begin
      logic [7:0] d;
      logic p, s;
      d = 8'($urandom_range(0, 255));
      p = odd_par(d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 5) != 0);
      frame_check($sformatf("R%0d %02h", k, d), d, p, s, HP_FAST);
    end

    // T6 short glitches in IDLE
    f0 = flag_cnt;
    e0 = err_cnt;
    iPs2Data = 1'b0;
    for (int g = 0; g < 10; g++) begin
      iPs2Clk = 1'b0;
      cycles(2);
      iPs2Clk = 1'b1;
      cycles(5);
    end
    iPs2Data = 1'b1;
    cycles(TO + 100);
    @(negedge iClk);
    chk("T6 glitch flag", flag_cnt - f0, 0);
    chk("T6 glitch err",  err_cnt - e0, 0);

    // T6 reset mid-frame
    send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 3, HP);
    iPs2Data = 1'b0;
    iPs2Clk  = 1'b0;
    cycles(100);
    iReset_n = 1'b0;
    cycles(10);
    iPs2Clk  = 1'b1;
    iPs2Data = 1'b1;
    cycles(10);
    @(negedge iClk);
    chk("T6 in-reset data", oData, 8'h00);
    f0 = flag_cnt;
    e0 = err_cnt;
    iReset_n = 1'b1;
    cycles(TO + 200);
    @(negedge iClk);
    chk("T6 post-reset flag cnt", flag_cnt - f0, 0);
    chk("T6 post-reset err cnt",  err_cnt - e0, 0);
    chk("T6 post-reset oFlag", oFlag, 0);
    chk("T6 post-reset oErr",  oErr, 0);
    chk("T6 post-reset oData", oData, 8'h00);
    chk("overlap flag/err", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
